// File: rtl/drone_sequence_player_if.sv
`default_nettype none
// ============================================================================
// Module      : drone_sequence_player_if
// Description : Command handshake between the sequence player and the
//               downstream motor/attitude controller.
//                 cmd       [3:0] command code (master -> slave)
//                 cmd_valid       cmd is being offered (master -> slave)
//                 cmd_ready       slave accepts cmd this edge (slave -> master)
//               A transfer happens on a rising edge with cmd_valid & cmd_ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface drone_sequence_player_if;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       cmd_ready;

    modport master (output cmd, output cmd_valid, input  cmd_ready);
    modport slave  (input  cmd, input  cmd_valid, output cmd_ready);
endinterface
`default_nettype wire

// File: rtl/drone_sequence_player.sv
`default_nettype none
// ============================================================================
// Module      : drone_sequence_player
// Description : Walks a 16x4 synchronous command ROM from START_ADDR to
//               LAST_ADDR, absorbs the ROM's one-cycle read latency, skips
//               NOP codes and offers each command over a valid/ready
//               handshake, then idles HOLD_CYCLES cycles before the next fetch.
// Ports       : clock        rising-edge system clock
//               reset        synchronous active-high reset (highest priority)
//               iniciar      start/restart, honoured only in IDLE and DONE
//               parar        synchronous abort to IDLE from any state
//               rom_address  registered ROM address
//               rom_data     ROM output, valid one edge after the address
//               cmd_if       command handshake (master side)
//               busy         high outside IDLE and DONE
//               pronto       high in DONE
//               cmd_count    commands accepted in the current run (0..16)
//               db_estado    current state code
// Revision    : 1.0 - initial release
// ============================================================================
module drone_sequence_player #(
    parameter int unsigned START_ADDR  = 0,
    parameter int unsigned LAST_ADDR   = 15,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter logic [3:0]  NOP_CODE    = 4'b0000
) (
    input  wire                     clock,
    input  wire                     reset,
    input  wire                     iniciar,
    input  wire                     parar,
    output logic [3:0]              rom_address,
    input  wire  [3:0]              rom_data,
    drone_sequence_player_if.master cmd_if,
    output logic                    busy,
    output logic                    pronto,
    output logic [4:0]              cmd_count,
    output logic [3:0]              db_estado
);

    localparam logic [3:0] c_S_IDLE  = 4'd0;
    localparam logic [3:0] c_S_FETCH = 4'd1;
    localparam logic [3:0] c_S_LATCH = 4'd2;
    localparam logic [3:0] c_S_ISSUE = 4'd3;
    localparam logic [3:0] c_S_HOLD  = 4'd4;
    localparam logic [3:0] c_S_NEXT  = 4'd5;
    localparam logic [3:0] c_S_DONE  = 4'd6;

    localparam logic [3:0]  c_START_ADDR = 4'(START_ADDR);
    localparam logic [3:0]  c_LAST_ADDR  = 4'(LAST_ADDR);
    localparam bit          c_HAS_HOLD   = (HOLD_CYCLES != 0);
    // Last counter value in HOLD; unused when there is no hold phase.
    localparam logic [15:0] c_HOLD_LAST  = c_HAS_HOLD ? 16'(HOLD_CYCLES - 1) : 16'd0;
    localparam logic [4:0]  c_COUNT_MAX  = 5'd16;

    logic [3:0]  r_state;
    logic [3:0]  w_state_next;
    logic [3:0]  r_rom_address;
    logic [3:0]  r_cmd;
    logic        r_cmd_valid;
    logic [4:0]  r_cmd_count;
    logic [15:0] r_hold_cnt;
    logic        w_transfer;
    logic        w_start;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_next = r_state;
        if (parar) begin
            w_state_next = c_S_IDLE;
        end else begin
            case (r_state)
                c_S_IDLE,
                c_S_DONE:  if (iniciar) w_state_next = c_S_FETCH;
                // The ROM captures rom_address on the edge that closes FETCH.
                c_S_FETCH: w_state_next = c_S_LATCH;
                c_S_LATCH: w_state_next = (rom_data == NOP_CODE) ? c_S_NEXT : c_S_ISSUE;
                c_S_ISSUE: if (w_transfer) w_state_next = c_HAS_HOLD ? c_S_HOLD : c_S_NEXT;
                c_S_HOLD:  if (r_hold_cnt == c_HOLD_LAST) w_state_next = c_S_NEXT;
                // LAST_ADDR is tested before incrementing, so 15 never wraps.
                c_S_NEXT:  w_state_next = (r_rom_address == c_LAST_ADDR) ? c_S_DONE : c_S_FETCH;
                default:   w_state_next = c_S_IDLE;
            endcase
        end
    end

    // --------------------------------------------------------------- outputs
    always_comb begin
        busy       = (r_state != c_S_IDLE) && (r_state != c_S_DONE);
        pronto     = (r_state == c_S_DONE);
        w_transfer = (r_state == c_S_ISSUE) && r_cmd_valid && cmd_if.cmd_ready;
        w_start    = ((r_state == c_S_IDLE) || (r_state == c_S_DONE)) && iniciar;
    end

    // -------------------------------------------------------------- datapath
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rom_address <= c_START_ADDR;
            r_cmd         <= 4'd0;
            r_cmd_valid   <= 1'b0;
            r_cmd_count   <= 5'd0;
            r_hold_cnt    <= 16'd0;
        end else if (parar) begin
            // Deliberate abort: the offer is withdrawn, the count is kept.
            r_cmd_valid <= 1'b0;
        end else begin
            if (w_start) begin
                r_rom_address <= c_START_ADDR;
                r_cmd_count   <= 5'd0;
            end
            if ((r_state == c_S_LATCH) && (rom_data != NOP_CODE)) begin
                r_cmd       <= rom_data;
                r_cmd_valid <= 1'b1;
            end
            if (w_transfer) begin
                r_cmd_valid <= 1'b0;
                r_hold_cnt  <= 16'd0;
                if (r_cmd_count != c_COUNT_MAX) begin
                    r_cmd_count <= r_cmd_count + 5'd1;
                end
            end
            if (r_state == c_S_HOLD) begin
                r_hold_cnt <= r_hold_cnt + 16'd1;
            end
            if ((r_state == c_S_NEXT) && (r_rom_address != c_LAST_ADDR)) begin
                r_rom_address <= r_rom_address + 4'd1;
            end
        end
    end

    assign rom_address      = r_rom_address;
    assign cmd_if.cmd       = r_cmd;
    assign cmd_if.cmd_valid = r_cmd_valid;
    assign cmd_count        = r_cmd_count;
    assign db_estado        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_drone_sequence_player.sv
`default_nettype none
// ============================================================================
// Module      : tb_drone_sequence_player
// Description : Self-checking bench. Two players (default configuration and
//               START=3/LAST=5/HOLD=0) read a modelled synchronous ROM; a
//               schedule-based model predicts handshake timing, commands and
//               status every cycle, and directed scenarios pin literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_drone_sequence_player;

    localparam int c_A_START = 0;
    localparam int c_A_LAST  = 15;
    localparam int c_A_HOLD  = 4;
    localparam int c_B_START = 3;
    localparam int c_B_LAST  = 5;
    localparam int c_B_HOLD  = 0;
    localparam logic [3:0] c_NOP = 4'b0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst [2];
    logic ini [2];
    logic par [2];
    logic rdy [2];

    logic [3:0] rom [16];
    logic [3:0] a_addr, b_addr, a_romq, b_romq, a_db, b_db;
    logic [4:0] a_cnt, b_cnt;
    logic       a_busy, b_busy, a_pronto, b_pronto;

    drone_sequence_player_if ifa ();
    drone_sequence_player_if ifb ();
    assign ifa.cmd_ready = rdy[0];
    assign ifb.cmd_ready = rdy[1];

    drone_sequence_player #(.START_ADDR(c_A_START), .LAST_ADDR(c_A_LAST),
                            .HOLD_CYCLES(c_A_HOLD), .NOP_CODE(c_NOP)) u_dut_a (
        .clock(clk), .reset(rst[0]), .iniciar(ini[0]), .parar(par[0]),
        .rom_address(a_addr), .rom_data(a_romq), .cmd_if(ifa.master),
        .busy(a_busy), .pronto(a_pronto), .cmd_count(a_cnt), .db_estado(a_db));

    drone_sequence_player #(.START_ADDR(c_B_START), .LAST_ADDR(c_B_LAST),
                            .HOLD_CYCLES(c_B_HOLD), .NOP_CODE(c_NOP)) u_dut_b (
        .clock(clk), .reset(rst[1]), .iniciar(ini[1]), .parar(par[1]),
        .rom_address(b_addr), .rom_data(b_romq), .cmd_if(ifb.master),
        .busy(b_busy), .pronto(b_pronto), .cmd_count(b_cnt), .db_estado(b_db));

    // Synchronous ROM: one registered read per player.
    always @(posedge clk) begin
        a_romq <= rom[a_addr];
        b_romq <= rom[b_addr];
    end

    // ------------------------------------------------------------ model
    // Run-level view: while a run is active the model only knows how many
    // edges remain until the next offer (or completion), derived from the
    // ROM contents: 2 edges to reach an offer, 3 per skipped NOP, HOLD+1
    // after each accepted command.
    typedef struct {
        bit run, done, offer, pend_offer, addr_known;
        int wait_n, pend_cmd, pend_addr, cmd, count, addr;
    } model_t;

    model_t m [2];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit checking = 1'b0;
    logic [3:0] xfer_a [$];
    logic [3:0] xfer_b [$];
    int xfer_b_t [$];
    int rise [2];
    logic prev_pronto [2];

    function automatic model_t plan(model_t mi, int p, int base, int last);
        model_t mo = mi;
        int k = 0;
        int q = p;
        while (q <= last && rom[q] == c_NOP) begin
            k++;
            q++;
        end
        if (q > last) begin
            mo.pend_offer = 1'b0;
            mo.wait_n = base + 3 * k;
        end else begin
            mo.pend_offer = 1'b1;
            mo.pend_cmd = int'(rom[q]);
            mo.pend_addr = q;
            mo.wait_n = base + 2 + 3 * k;
        end
        return mo;
    endfunction

    function automatic model_t step(model_t mi, logic r, logic st, logic pa, logic rd,
                                    int start, int last, int hold);
        model_t mo = mi;
        if (r) begin
            mo.run = 0; mo.done = 0; mo.offer = 0; mo.cmd = 0; mo.count = 0;
            mo.addr = start; mo.addr_known = 1;
        end else if (pa) begin
            mo.run = 0; mo.done = 0; mo.offer = 0; mo.addr_known = 0;
        end else if (!mo.run) begin
            if (st) begin
                mo.run = 1; mo.done = 0; mo.count = 0; mo.addr_known = 0;
                mo = plan(mo, start, 0, last);
            end
        end else if (mo.offer) begin
            if (rd) begin
                mo.offer = 0;
                if (mo.count < 16) mo.count++;
                mo.addr_known = 0;
                mo = plan(mo, mo.addr + 1, hold + 1, last);
            end
        end else begin
            mo.wait_n--;
            if (mo.wait_n == 0) begin
                if (mo.pend_offer) begin
                    mo.offer = 1; mo.cmd = mo.pend_cmd; mo.addr = mo.pend_addr; mo.addr_known = 1;
                end else begin
                    mo.run = 0; mo.done = 1; mo.addr = last; mo.addr_known = 1;
                end
            end
        end
        return mo;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_dut(int i, logic v, logic [3:0] c, logic b, logic p,
                             logic [4:0] n, logic [3:0] ad, logic [3:0] db);
        model_t e = m[i];
        chk($sformatf("d%0d cmd_valid", i), 32'(v), 32'(e.offer));
        chk($sformatf("d%0d cmd", i), 32'(c), 32'(e.cmd));
        chk($sformatf("d%0d busy", i), 32'(b), 32'(e.run));
        chk($sformatf("d%0d pronto", i), 32'(p), 32'(e.done));
        chk($sformatf("d%0d cmd_count", i), 32'(n), 32'(e.count));
        if (e.addr_known) chk($sformatf("d%0d rom_address", i), 32'(ad), 32'(e.addr));
        if (e.offer)          chk($sformatf("d%0d db_estado", i), 32'(db), 32'd3);
        else if (e.done)      chk($sformatf("d%0d db_estado", i), 32'(db), 32'd6);
        else if (!e.run)      chk($sformatf("d%0d db_estado", i), 32'(db), 32'd0);
        else begin
            vectors++;
            if (!(db inside {4'd1, 4'd2, 4'd4, 4'd5})) begin
                miscompares++;
                $display("FAIL d%0d db_estado: got %0d, expected one of 1,2,4,5 (cycle %0d)", i, db, cyc);
            end
        end
    endtask

    // Single compare process: advance the model on each edge, check #1 later.
    always @(posedge clk) begin
        cyc++;
        if (ifa.cmd_valid === 1'b1 && rdy[0] && !rst[0] && !par[0]) xfer_a.push_back(ifa.cmd);
        if (ifb.cmd_valid === 1'b1 && rdy[1] && !rst[1] && !par[1]) begin
            xfer_b.push_back(ifb.cmd);
            xfer_b_t.push_back(cyc);
        end
        m[0] = step(m[0], rst[0], ini[0], par[0], rdy[0], c_A_START, c_A_LAST, c_A_HOLD);
        m[1] = step(m[1], rst[1], ini[1], par[1], rdy[1], c_B_START, c_B_LAST, c_B_HOLD);
        #1;
        if (checking) begin
            check_dut(0, ifa.cmd_valid, ifa.cmd, a_busy, a_pronto, a_cnt, a_addr, a_db);
            check_dut(1, ifb.cmd_valid, ifb.cmd, b_busy, b_pronto, b_cnt, b_addr, b_db);
        end
        if (a_pronto === 1'b1 && prev_pronto[0] !== 1'b1) rise[0] = cyc;
        if (b_pronto === 1'b1 && prev_pronto[1] !== 1'b1) rise[1] = cyc;
        prev_pronto[0] = a_pronto;
        prev_pronto[1] = b_pronto;
    end

    // ---------------------------------------------------------- stimulus
    task automatic pulse_ini(int i);
        @(negedge clk); ini[i] = 1'b1;
        @(negedge clk); ini[i] = 1'b0;
    endtask

    initial begin : stim
        int t;
        int t0;
        logic [3:0] exp_a [5];
        logic [3:0] exp_b [3];
        exp_a = '{4'b1010, 4'b0010, 4'b0100, 4'b0101, 4'b0001};
        exp_b = '{4'b0100, 4'b0101, 4'b0001};
        rom = '{4'b0000, 4'b1010, 4'b0010, 4'b0100, 4'b0101, 4'b0001, 4'b0110, 4'b0011,
                4'b1000, 4'b1001, 4'b0111, 4'b1100, 4'b1011, 4'b1110, 4'b1101, 4'b0101};
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; ini[i] = 1'b0; par[i] = 1'b0; rdy[i] = 1'b0;
            prev_pronto[i] = 1'b0; rise[i] = 0;
        end
        repeat (3) @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0;
        checking = 1'b1;

        // Reset state after 5 idle cycles.
        repeat (5) @(negedge clk);
        chk("reset A rom_address", 32'(a_addr), 32'd0);
        chk("reset B rom_address", 32'(b_addr), 32'd3);
        chk("reset A cmd_valid", 32'(ifa.cmd_valid), 32'd0);
        chk("reset A busy/pronto/db", {a_busy, a_pronto, a_db}, 32'd0);

        // Full default run.
        rdy[0] = 1'b1;
        xfer_a.delete();
        pulse_ini(0);
        t0 = cyc;
        t = 0;
        while (a_pronto !== 1'b1 && t < 400) begin @(negedge clk); t++; end
        chk("A run reaches DONE", 32'(a_pronto), 32'd1);
        chk("A edges to pronto", 32'(rise[0] - t0), 32'd123);
        chk("A run cmd_count", 32'(a_cnt), 32'd15);
        chk("A transfers", 32'(xfer_a.size()), 32'd15);
        for (int k = 0; k < 5; k++) chk($sformatf("A cmd #%0d", k), 32'(xfer_a[k]), 32'(exp_a[k]));

        // Backpressure on the first command, then hold length.
        rdy[0] = 1'b0;
        pulse_ini(0);
        t = 0;
        while (ifa.cmd_valid !== 1'b1 && t < 20) begin @(negedge clk); t++; end
        chk("A pending cmd", 32'(ifa.cmd), 32'(4'b1010));
        repeat (5) @(negedge clk);
        chk("A held valid", 32'(ifa.cmd_valid), 32'd1);
        chk("A held cmd", 32'(ifa.cmd), 32'(4'b1010));
        rdy[0] = 1'b1;
        @(negedge clk);
        t = 0;
        while (a_db == 4'd4 && t < 20) begin @(negedge clk); t++; end
        chk("A hold length", 32'(t), 32'd4);
        @(negedge clk); par[0] = 1'b1;
        @(negedge clk); par[0] = 1'b0;

        // Abort in HOLD after the 2nd command, then restart.
        xfer_a.delete();
        pulse_ini(0);
        t = 0;
        while (xfer_a.size() < 2 && t < 100) begin @(negedge clk); t++; end
        chk("A in HOLD before abort", 32'(a_db), 32'd4);
        par[0] = 1'b1;
        @(negedge clk); par[0] = 1'b0;
        chk("abort busy", 32'(a_busy), 32'd0);
        chk("abort cmd_count", 32'(a_cnt), 32'd2);
        chk("abort cmd_valid", 32'(ifa.cmd_valid), 32'd0);
        pulse_ini(0);
        chk("restart cmd_count", 32'(a_cnt), 32'd0);
        t = 0;
        while (ifa.cmd_valid !== 1'b1 && t < 20) begin @(negedge clk); t++; end
        chk("restart first cmd", 32'(ifa.cmd), 32'(4'b1010));
        chk("restart address", 32'(a_addr), 32'd1);

        // Reset while offering with cmd_ready low; iniciar in that cycle ignored.
        rdy[0] = 1'b0;
        @(negedge clk); rst[0] = 1'b1; ini[0] = 1'b1;
        @(negedge clk); rst[0] = 1'b0; ini[0] = 1'b0;
        chk("reset-in-ISSUE address", 32'(a_addr), 32'd0);
        chk("reset-in-ISSUE cmd", 32'(ifa.cmd), 32'd0);
        chk("reset-in-ISSUE flags", {ifa.cmd_valid, a_busy, a_pronto, a_cnt, a_db}, 32'd0);
        @(negedge clk);
        chk("reset-in-ISSUE stays idle", 32'(a_busy), 32'd0);

        // Short range, no hold.
        rdy[1] = 1'b1;
        xfer_b.delete(); xfer_b_t.delete();
        pulse_ini(1);
        t = 0;
        while (b_pronto !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        chk("B transfers", 32'(xfer_b.size()), 32'd3);
        for (int k = 0; k < 3; k++) chk($sformatf("B cmd #%0d", k), 32'(xfer_b[k]), 32'(exp_b[k]));
        for (int k = 1; k < 3; k++) chk($sformatf("B slot %0d", k), 32'(xfer_b_t[k] - xfer_b_t[k-1]), 32'd4);
        chk("B cmd_count", 32'(b_cnt), 32'd3);
        chk("B final address", 32'(b_addr), 32'd5);

        // parar + iniciar together in IDLE.
        @(negedge clk); par[1] = 1'b1;
        @(negedge clk); ini[1] = 1'b1;
        @(negedge clk); par[1] = 1'b0; ini[1] = 1'b0;
        chk("B parar+iniciar idle", 32'(b_busy), 32'd0);

        // Randomized traffic with randomized ROM images.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 2; i++) begin
                rst[i] = 1'b1; ini[i] = 1'b0; par[i] = 1'b0;
            end
            @(negedge clk);
            for (int k = 0; k < 16; k++)
                rom[k] = ($urandom_range(0, 2) == 0) ? c_NOP : 4'($urandom_range(1, 15));
            @(negedge clk);
            rst[0] = 1'b0; rst[1] = 1'b0;
            for (int c = 0; c < 1500; c++) begin
                for (int i = 0; i < 2; i++) begin
                    rdy[i] = ($urandom_range(0, 9) < 7);
                    ini[i] = ($urandom_range(0, 19) == 0);
                    par[i] = ($urandom_range(0, 199) == 0);
                    rst[i] = ($urandom_range(0, 399) == 0);
                end
                @(negedge clk);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
